parallel_to_serial: RTL
=======================

Name: parallel_to_serial

Overview:
- Transmit-side counterpart of the team's serial-to-parallel receiver.
- Accepts N-bit parallel words over a valid/ready handshake and emits them as a continuous, frame-aligned serial bit stream, LSB first.
- Frame boundaries repeat every N cycles, starting at bit index 0 after reset, so a receiver released from reset on the same clock edge captures each word intact.
- A one-word holding buffer lets the producer stage the next word while the current frame is shifting; frames with no data are filled with idle bits and flagged.

Parameters:
- N, 8, word width in bits and frame length in cycles (N >= 2).
- IDLE_BIT, 1'b0, value driven on serial_out for every bit of an idle frame.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- data_in  input  N  parallel word; sampled when valid_in && ready_out.
- valid_in  input  1  producer has a word on data_in.
- ready_out  output  1  holding buffer can accept a word this cycle.
- serial_out  output  1  serial bit for the current frame bit index.
- frame_tick  output  1  high during the cycle that carries bit 0 of a frame.
- idle_frame  output  1  high for all N cycles of a frame that carries filler, not user data.

Behaviour:
- State:
  - count_reg: 0..N-1, free-running, wraps N-1 -> 0.
  - shift_reg: N bits.
  - hold_reg: N bits, plus hold_full flag.
  - idle_reg: 1 bit.
- Reset (reset==0, asynchronous):
  - count_reg=0, shift_reg={N{IDLE_BIT}}, hold_full=0, hold_reg=0, idle_reg=1.
  - Any staged or in-flight word is discarded, with no partial completion.
- Output reset values:
  - serial_out=IDLE_BIT, frame_tick=1, idle_frame=1, ready_out=1.
- Output sources:
  - serial_out = shift_reg[0].
  - frame_tick = (count_reg==0).
  - idle_frame = idle_reg.
  - ready_out = ~hold_full.
  - All outputs are combinational from registers only; ready_out does not depend on valid_in.
- Frame timing:
  - In the cycle with count_reg==k, serial_out carries bit k of the current frame word.
  - The first frame after reset release is an idle frame.
- Shift: when count_reg != N-1, shift_reg shifts right by one each cycle, with IDLE_BIT filling the MSB.
- Accept: when valid_in && ready_out, data_in is captured.
  - If count_reg != N-1: data_in goes to hold_reg and hold_full becomes 1.
- Frame load, at the clock edge where count_reg==N-1, in priority order:
  - (a) hold_full=1: shift_reg<=hold_reg, hold_full<=0, idle_reg<=0. A simultaneous handshake is impossible because ready_out=0.
  - (b) hold_full=0 and handshake this cycle: bypass, shift_reg<=data_in, idle_reg<=0, hold_full stays 0.
  - (c) otherwise: shift_reg<={N{IDLE_BIT}}, idle_reg<=1.
- Latency:
  - Word accepted while count_reg==N-1 with hold empty: its bit 0 appears on the next cycle.
  - Word accepted at count_reg=c<N-1: its bit 0 appears N-c cycles later.
- Backpressure:
  - Capacity is one staged word plus one in flight.
  - ready_out drops the cycle after an accept into hold and rises the cycle after the next frame load.
  - valid_in held with ready_out=0 leaves data_in ignored; the producer must hold the word stable.
- Throughput: a producer keeping valid_in high achieves back-to-back frames with zero idle frames.
- No mid-frame abort: frames always complete; only reset truncates a frame.

Test Plan:
- Reset release, valid_in=0 for 3 frames (N=8):
  - serial_out=0 throughout; idle_frame=1.
  - frame_tick=1 at cycles 0, 8, 16; ready_out=1.
- Single word 8'hA5 accepted at count_reg=3:
  - ready_out=0 from the next cycle.
  - Frame starting 5 cycles after the accept emits 1,0,1,0,0,1,0,1 with idle_frame=0.
  - ready_out returns to 1 at that frame's bit 0.
- Bypass: 8'h3C accepted exactly at count_reg==7 with hold empty:
  - Next cycle frame_tick=1 and serial sequence is 0,0,1,1,1,1,0,0.
  - ready_out never deasserts.
- Back-to-back words 8'h01, 8'hFF, 8'h80 with valid_in held high:
  - Three consecutive non-idle frames, decoded by a loopback serial_to_parallel instance as 01, FF, 80.
  - Followed by an idle frame.
- Reset mid-frame with hold full (0x55 in flight, 0xAA staged, reset low at count_reg=4):
  - Outputs take reset values immediately.
  - After release, the first frame is idle and neither word is ever emitted.
- IDLE_BIT=1, N=4, no data:
  - serial_out constantly 1; frame_tick every 4 cycles.
  - Word 4'h6 produces 0,1,1,0 in its frame.

Source files
------------

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: frame-aligned LSB-first serializer with a one-word holding buffer.
module parallel_to_serial #(
  parameter int   N        = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic         serial_out,
  output logic         frame_tick,
  output logic         idle_frame
);
  localparam int CW = $clog2(N);
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_shift;
  logic [N-1:0]  r_hold;
  logic          r_hold_full;
  logic          r_idle;
  logic          w_last;
  logic          w_accept;
  assign w_last     = r_count == CW'(N - 1);
  assign w_accept   = valid_in && !r_hold_full;
  assign ready_out  = ~r_hold_full;
  assign serial_out = r_shift[0];
  assign frame_tick = r_count == '0;
  assign idle_frame = r_idle;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_count     <= '0;
      r_shift     <= {N{IDLE_BIT}};
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_idle      <= 1'b1;
    end else begin
      r_count <= w_last ? '0 : r_count + CW'(1);
      if (w_last) begin
        // staged word wins; otherwise a word offered right now bypasses the buffer
        if (r_hold_full) begin
          r_shift     <= r_hold;
          r_hold_full <= 1'b0;
          r_idle      <= 1'b0;
        end else if (valid_in) begin
          r_shift <= data_in;
          r_idle  <= 1'b0;
        end else begin
          r_shift <= {N{IDLE_BIT}};
          r_idle  <= 1'b1;
        end
      end else begin
        r_shift <= {IDLE_BIT, r_shift[N-1:1]};
        if (w_accept) begin
          r_hold      <= data_in;
          r_hold_full <= 1'b1;
        end
      end
    end
endmodule
